serial_tx_ctrl: RTL and testbench
=================================

// Module: serial_tx_ctrl
// PURPOSE
//  Framed serial transmitter controller. Accepts a WIDTH-bit word over a valid/ready
//  handshake and sequences an internal parallel-load/shift-right register to emit
//  start bit (0), WIDTH data bits LSB-first, and stop bit (1). Each bit lasts DIV clocks.
//  Sits between the game/control logic and an off-chip serial pin (UART-style debug or
//  peripheral link).
// PARAMETERS
//  WIDTH  8  data bits per frame (>=2)
//  DIV    4  clocks per serial bit (>=2)
// PORTS
//  Clk         in   1      system clock, all state updates on posedge
//  Reset       in   1      asynchronous, active-low reset (0 = reset)
//  In_Valid    in   1      word available on In_Data
//  In_Ready    out  1      controller can accept a word this cycle
//  In_Data     in   WIDTH  word to transmit, sampled only on handshake
//  Abort       in   1      synchronous frame cancel, active-high
//  Ser_Out     out  1      serial line, idles high
//  Ser_Active  out  1      high while a frame is in progress
//  Done        out  1      one-cycle pulse, frame completed normally
// BEHAVIOUR
//  - Reset (async, active-low): state=IDLE, shift reg=0, counters=0, Ser_Out=1,
//    Ser_Active=0, Done=0. In_Ready=1 during/after reset unless Abort=1.
//  - In_Ready = (state==IDLE) && !Abort, combinational from registered state.
//  - Handshake = In_Valid && In_Ready, at cycle k: In_Data loaded into shift reg,
//    state->START. Ser_Out low starting at k+1 (registered output, latency 1).
//  - FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//    START: DIV cycles, Ser_Out=0.
//    DATA: WIDTH bits x DIV cycles, Ser_Out=shift[0]. Shift right by 1 (zero-fill)
//    on the last cycle of each bit. bit_cnt 0..WIDTH-1, DATA->STOP at bit_cnt==WIDTH-1
//    and bit end.
//    STOP: DIV cycles, Ser_Out=1. Done=1 in the last STOP cycle, then IDLE.
//  - div_cnt: 0..DIV-1, width $clog2(DIV). Cleared on handshake and on Abort.
//    bit_end = (div_cnt==DIV-1).
//  - bit_cnt: width $clog2(WIDTH). Wraps only via reset on frame start. Never reaches WIDTH.
//  - Frame = (WIDTH+2)*DIV cycles. Min period = frame+1, because one IDLE cycle with
//    Ser_Out=1 sits between frames.
//  - In_Data changes after the handshake have no effect on the frame.
//  - Ser_Active = (state != IDLE).
//  - Abort (any non-IDLE state): next cycle IDLE, Ser_Out=1, counters cleared, no Done.
//    Abort in IDLE blocks acceptance (In_Ready=0).
//    Abort in the last STOP cycle: Done suppressed.
//  - Reset mid-frame: line returns high immediately (async), frame lost, no Done.
// STRUCTURE
//  - Package serial_tx_pkg: typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA,
//    TX_STOP} tx_state_t.
//  - Sub-module bit_tick_gen #(DIV): div_cnt plus bit_end output, with sync clear input.
//  - Shift register and bit_cnt live inline.
// TESTING  (WIDTH=8, DIV=4, handshake at cycle 0)
//  1. Hold Reset=0 for 3 cycles, release -> Ser_Out=1, Ser_Active=0, Done=0, In_Ready=1.
//  2. Send 8'hA5 -> Ser_Out=0 cycles 1-4; bits 1,0,1,0,0,1,0,1 for 4 cycles each,
//     cycles 5-36; Ser_Out=1 cycles 37-40; Done=1 only at cycle 40; In_Ready=1 at 41.
//  3. In_Valid held high with 8'h00 then 8'hFF -> second handshake at cycle 41,
//     second start bit cycles 42-45, data all-ones cycles 46-77.
//  4. Send 8'h3C, Abort=1 at cycle 17 (DATA bit 3) -> cycle 18 Ser_Out=1,
//     Ser_Active=0; Done never pulses; In_Ready=1 once Abort drops.
//  5. Send 8'h81, change In_Data to 8'h7E at cycle 1 -> line still carries 8'h81.
//  6. Reset=0 asynchronously at cycle 20 of a frame -> Ser_Out=1 before the next edge;
//     a new 8'h5A frame after release is bit-exact and asserts Done.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types for the framed serial transmitter.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/bit_tick_gen.sv
// Per-bit clock divider: counts 0..DIV-1 while enabled and flags the last cycle of each bit.
module bit_tick_gen #(
    parameter int DIV = 4,
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic bit_end
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
        end else if (clr) begin
            div_cnt_reg <= '0;
        end else if (en) begin
            div_cnt_reg <= bit_end ? '0 : div_cnt_reg + 1'b1;
        end
    end

    assign bit_end = (div_cnt_reg == LAST);

endmodule

// File: rtl/serial_tx_ctrl.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB-first, stop bit, DIV clocks per bit.
module serial_tx_ctrl
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] In_Data,
    input  logic             Abort,
    output logic             Ser_Out,
    output logic             Ser_Active,
    output logic             Done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    tx_state_t        state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic             ser_out_reg, ser_out_next;
    logic             handshake;
    logic             bit_end;
    logic             tick_en;
    logic             tick_clr;

    assign handshake = In_Valid && In_Ready;
    assign tick_en   = (state_reg != TX_IDLE);
    assign tick_clr  = handshake || Abort;

    bit_tick_gen #(.DIV(DIV)) u_tick (
        .clk     (Clk),
        .rst_n   (Reset),
        .clr     (tick_clr),
        .en      (tick_en),
        .bit_end (bit_end)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg <= TX_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            TX_IDLE:  if (handshake) state_next = TX_START;
            TX_START: if (bit_end) state_next = TX_DATA;
            TX_DATA:  if (bit_end && (bit_cnt_reg == BIT_LAST)) state_next = TX_STOP;
            TX_STOP:  if (bit_end) state_next = TX_IDLE;
            default:  state_next = TX_IDLE;
        endcase
        if (Abort && (state_reg != TX_IDLE)) begin
            state_next = TX_IDLE;
        end
    end

    // Shift register and bit counter; the counter is only re-zeroed at frame start or cancel.
    always_comb begin
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        if (handshake) begin
            shift_next   = In_Data;
            bit_cnt_next = '0;
        end else if (Abort) begin
            shift_next   = '0;
            bit_cnt_next = '0;
        end else if ((state_reg == TX_DATA) && bit_end) begin
            shift_next = {1'b0, shift_reg[WIDTH-1:1]};
            if (bit_cnt_reg != BIT_LAST) begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            ser_out_reg <= 1'b1;
        end else begin
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            ser_out_reg <= ser_out_next;
        end
    end

    // Line level is decoded from next-state values so the pin itself comes straight from a flop.
    always_comb begin
        In_Ready     = (state_reg == TX_IDLE) && !Abort;
        Ser_Active   = (state_reg != TX_IDLE);
        Done         = (state_reg == TX_STOP) && bit_end && !Abort;
        ser_out_next = 1'b1;
        case (state_next)
            TX_START: ser_out_next = 1'b0;
            TX_DATA:  ser_out_next = shift_next[0];
            default:  ser_out_next = 1'b1;
        endcase
    end

    assign Ser_Out = ser_out_reg;

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Directed bench for serial_tx_ctrl (WIDTH=8, DIV=4): frame timing, back-to-back, abort, reset.
module tb_serial_tx_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       In_Valid = 1'b0;
    logic       In_Ready;
    logic [7:0] In_Data = 8'h00;
    logic       Abort = 1'b0;
    logic       Ser_Out;
    logic       Ser_Active;
    logic       Done;

    int n_cmp = 0;
    int n_err = 0;

    serial_tx_ctrl #(.WIDTH(8), .DIV(4)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .In_Data    (In_Data),
        .Abort      (Abort),
        .Ser_Out    (Ser_Out),
        .Ser_Active (Ser_Active),
        .Done       (Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Cycle 0 is the handshake cycle; expected line per cycle: 1-4 start, 5-36 data, 37-40 stop.
    task automatic run_frame(input logic [7:0] data, input int abort_at, input int rst_at,
                             input logic valid_after, input logic [7:0] data_after);
        logic exp_o;
        In_Valid = 1'b1;
        In_Data  = data;
        Abort    = 1'b0;
        @(negedge Clk);
        check("rdy_c0", {31'd0, In_Ready}, 32'd1);
        @(posedge Clk); #1;
        In_Valid = valid_after;
        In_Data  = data_after;
        for (int c = 1; c <= 40; c++) begin
            if (c == abort_at) Abort = 1'b1;
            @(negedge Clk);
            if (c <= 4)       exp_o = 1'b0;
            else if (c <= 36) exp_o = data[(c - 5) / 4];
            else              exp_o = 1'b1;
            check($sformatf("ser_c%0d", c), {31'd0, Ser_Out}, {31'd0, exp_o});
            check($sformatf("act_c%0d", c), {31'd0, Ser_Active}, 32'd1);
            check($sformatf("done_c%0d", c), {31'd0, Done}, {31'd0, (c == 40) && (abort_at != 40)});
            check($sformatf("rdy_c%0d", c), {31'd0, In_Ready}, 32'd0);
            if (c == rst_at) begin
                Reset = 1'b0;
                #1;
                check("rst_ser", {31'd0, Ser_Out}, 32'd1);
                check("rst_act", {31'd0, Ser_Active}, 32'd0);
                check("rst_done", {31'd0, Done}, 32'd0);
                @(posedge Clk);
                @(posedge Clk); #1;
                Reset    = 1'b1;
                In_Valid = 1'b0;
                $display("frame %02h reset at cycle %0d", data, c);
                return;
            end
            @(posedge Clk); #1;
            if (c == abort_at) begin
                Abort    = 1'b0;
                In_Valid = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge Clk);
                    check("abt_ser", {31'd0, Ser_Out}, 32'd1);
                    check("abt_act", {31'd0, Ser_Active}, 32'd0);
                    check("abt_done", {31'd0, Done}, 32'd0);
                    check("abt_rdy", {31'd0, In_Ready}, 32'd1);
                    @(posedge Clk); #1;
                end
                $display("frame %02h aborted at cycle %0d", data, c);
                return;
            end
        end
        $display("frame %02h complete", data);
    endtask

    initial begin
        // Reset held low for three cycles
        repeat (3) @(posedge Clk);
        #1;
        check("rst_ser_hold", {31'd0, Ser_Out}, 32'd1);
        check("rst_rdy_hold", {31'd0, In_Ready}, 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        check("post_rst_ser", {31'd0, Ser_Out}, 32'd1);
        check("post_rst_act", {31'd0, Ser_Active}, 32'd0);
        check("post_rst_done", {31'd0, Done}, 32'd0);
        check("post_rst_rdy", {31'd0, In_Ready}, 32'd1);
        $display("reset released");

        // Abort while idle refuses the word
        @(posedge Clk); #1;
        Abort    = 1'b1;
        In_Valid = 1'b1;
        In_Data  = 8'h55;
        @(negedge Clk);
        check("idle_abt_rdy", {31'd0, In_Ready}, 32'd0);
        @(posedge Clk); #1;
        Abort    = 1'b0;
        In_Valid = 1'b0;
        @(negedge Clk);
        check("idle_abt_act", {31'd0, Ser_Active}, 32'd0);
        check("idle_abt_ser", {31'd0, Ser_Out}, 32'd1);
        $display("idle abort blocked word 55");
        @(posedge Clk); #1;

        run_frame(8'hA5, 0, 0, 1'b0, 8'h00);
        run_frame(8'h00, 0, 0, 1'b1, 8'hFF);
        run_frame(8'hFF, 0, 0, 1'b0, 8'h00);
        run_frame(8'h3C, 17, 0, 1'b0, 8'h00);
        run_frame(8'h81, 0, 0, 1'b0, 8'h7E);
        run_frame(8'hC3, 0, 20, 1'b0, 8'h00);
        run_frame(8'h5A, 0, 0, 1'b0, 8'h00);

        @(negedge Clk);
        check("end_act", {31'd0, Ser_Active}, 32'd0);
        check("end_ser", {31'd0, Ser_Out}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
